// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a framed stream (16-bit word count, little-endian
// instruction words, 8-bit additive checksum), writes the words into instruction memory
// and keeps the core in reset until a frame has been loaded and verified.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [CNT_WIDTH-1:0]  bad_op_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           count_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            lane_q;
  logic [7:0]            sum_q;
  logic [23:0]           lanes_q;   // bytes 0..2 of the word being assembled
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            err_code_q;
  logic [CNT_WIDTH-1:0]  bad_q;

  logic        accept;
  logic        restart;
  logic [15:0] hdr_count;
  logic        len_bad;
  logic        last_word;
  logic [31:0] word;
  logic        word_bad;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011,
      7'b0010011, 7'b1100011, 7'b1101111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign accept    = rx_valid && rx_ready;
  assign restart   = start && ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign hdr_count = {rx_data, count_q[7:0]};
  assign len_bad   = (hdr_count == 16'd0) || (32'(hdr_count) > DEPTH);
  assign last_word = (32'(idx_q) == (32'(count_q) - 32'd1));
  // The fourth byte completes the word straight off the input, no extra cycle.
  assign word      = {rx_data, lanes_q};
  assign word_bad  = !op_supported(word[6:0]);

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign err_code     = err_code_q;
  assign bad_op_count = bad_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_d   = state_q;
    rx_ready  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (state_q)
      StIdle, StDone, StErr: begin
        done      = (state_q == StDone);
        error     = (state_q == StErr);
        cpu_reset = (state_q != StDone);
        if (start) state_d = StHdr0;
      end
      StHdr0: begin
        rx_ready = 1'b1;
        if (accept) state_d = StHdr1;
      end
      StHdr1: begin
        rx_ready = 1'b1;
        if (accept) state_d = len_bad ? StErr : StData;
      end
      StData: begin
        rx_ready = 1'b1;
        if (accept && (lane_q == 2'd3) && last_word) state_d = StCsum;
      end
      StCsum: begin
        rx_ready = 1'b1;
        if (accept) state_d = (rx_data == sum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame datapath: header count, byte lanes, checksum, write port and opcode counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      idx_q      <= '0;
      lane_q     <= '0;
      sum_q      <= '0;
      lanes_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_code_q <= '0;
      bad_q      <= '0;
    end else begin
      we_q <= 1'b0;
      if (restart) begin
        idx_q      <= '0;
        lane_q     <= '0;
        sum_q      <= '0;
        err_code_q <= '0;
        bad_q      <= '0;
      end else if (accept) begin
        case (state_q)
          StHdr0: count_q[7:0] <= rx_data;
          StHdr1: begin
            count_q[15:8] <= rx_data;
            if (len_bad) err_code_q <= 2'b01;
          end
          StData: begin
            sum_q  <= sum_q + rx_data;
            lane_q <= lane_q + 2'd1;
            case (lane_q)
              2'd0: lanes_q[7:0]   <= rx_data;
              2'd1: lanes_q[15:8]  <= rx_data;
              2'd2: lanes_q[23:16] <= rx_data;
              default: begin
                we_q    <= 1'b1;
                waddr_q <= idx_q;
                wdata_q <= word;
                idx_q   <= idx_q + ADDR_WIDTH'(1);
                if (word_bad && (bad_q != {CNT_WIDTH{1'b1}})) begin
                  bad_q <= bad_q + CNT_WIDTH'(1);
                end
              end
            endcase
          end
          StCsum: if (rx_data != sum_q) err_code_q <= 2'b10;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames compared
// against a frame-level model of expected writes and final status.
module tb_imem_loader;

  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [CW-1:0] bad_op_count;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .cpu_reset   (cpu_reset),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .bad_op_count(bad_op_count)
  );

  int checks = 0;
  int errors = 0;
  int gap_pct = 0;
  bit noisy_start = 1'b0;

  logic [7:0]    frame[$];
  logic [AW-1:0] got_wa[$];
  logic [31:0]   got_wd[$];
  logic [AW-1:0] exp_wa[$];
  logic [31:0]   exp_wd[$];
  logic          exp_done, exp_error;
  logic [1:0]    exp_code;
  logic [CW-1:0] exp_bad;
  logic [6:0]    good_ops[6] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      got_wa.push_back(waddr);
      got_wd.push_back(wdata);
    end
  end

  // Frame-level model: decode the byte list into expected writes and final status.
  task automatic model_frame();
    int n, sum, bad;
    logic [31:0] w;
    exp_wa.delete();
    exp_wd.delete();
    n   = int'(frame[0]) + 256 * int'(frame[1]);
    sum = 0;
    bad = 0;
    exp_bad = '0;
    if (n == 0 || n > DEPTH) begin
      exp_done = 1'b0; exp_error = 1'b1; exp_code = 2'b01;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]};
      for (int k = 0; k < 4; k++) sum += int'(frame[2+4*i+k]);
      exp_wa.push_back(AW'(i));
      exp_wd.push_back(w);
      if (!(w[6:0] inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F}) && bad < 255) bad++;
    end
    exp_bad = CW'(bad);
    if (int'(frame[2+4*n]) == sum % 256) begin
      exp_done = 1'b1; exp_error = 1'b0; exp_code = 2'b00;
    end else begin
      exp_done = 1'b0; exp_error = 1'b1; exp_code = 2'b10;
    end
  endtask

  // Build a well-formed frame of n random words; corrupt makes the checksum wrong.
  task automatic build_frame(input int n, input bit corrupt);
    logic [31:0] w;
    logic [7:0]  s;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if ($urandom_range(1) == 1) w[6:0] = good_ops[$urandom_range(5)];
      for (int k = 0; k < 4; k++) begin
        frame.push_back(w[8*k +: 8]);
        s = s + w[8*k +: 8];
      end
    end
    frame.push_back(corrupt ? s + 8'd1 + 8'($urandom_range(254)) : s);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Start a load and stream the current frame, with optional idle gaps and stray starts.
  task automatic send_frame();
    got_wa.delete();
    got_wd.delete();
    pulse_start();
    foreach (frame[i]) begin
      if ($urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(3, 1)) begin
          rx_data = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      rx_valid = 1'b1;
      rx_data  = frame[i];
      start    = noisy_start && ($urandom_range(3) == 0);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      start    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({rx_ready, we, waddr, wdata, cpu_reset, done, error, err_code, bad_op_count} !==
        {1'b0, 1'b0, AW'(0), 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b we=%b wa=%0d wd=%h cr=%b d=%b e=%b ec=%b bad=%0d",
               rx_ready, we, waddr, wdata, cpu_reset, done, error, err_code, bad_op_count);
    end
  endtask

  task automatic test_basic();
    logic [7:0] csums[2] = '{8'h52, 8'h63};  // 0x52 is the true payload sum
    for (int c = 0; c < 2; c++) begin
      frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, csums[c]};
      model_frame();
      send_frame();
      checks++;
      if (got_wa.size() != 2 || got_wa[0] !== 0 || got_wd[0] !== 32'h00500093 ||
          got_wa[1] !== 1 || got_wd[1] !== 32'h0000006F) begin
        errors++;
        $display("FAIL basic_writes[%0d]: got %0d writes, first wd=%h, required 2 writes 00500093/0000006F",
                 c, got_wa.size(), (got_wd.size() > 0) ? got_wd[0] : 32'hx);
      end
      checks++;
      if ({done, error, err_code, cpu_reset, rx_ready, bad_op_count} !==
          {exp_done, exp_error, exp_code, ~exp_done, 1'b0, exp_bad}) begin
        errors++;
        $display("FAIL basic_status[%0d]: got d=%b e=%b ec=%b cr=%b bad=%0d required d=%b e=%b ec=%b",
                 c, done, error, err_code, cpu_reset, bad_op_count, exp_done, exp_error, exp_code);
      end
    end
  endtask

  task automatic test_length();
    logic [7:0] hi[3] = '{8'h00, 8'h00, 8'h01};
    logic [7:0] lo[3] = '{8'h00, 8'h41, 8'h00};
    for (int c = 0; c < 3; c++) begin
      frame = '{lo[c], hi[c]};
      send_frame();
      checks++;
      if ({got_wa.size() == 0, done, error, err_code, cpu_reset, rx_ready} !==
          {1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL length_err[%0d]: got writes=%0d d=%b e=%b ec=%b cr=%b, required no writes, ERR code 01",
                 c, got_wa.size(), done, error, err_code, cpu_reset);
      end
    end
  endtask

  task automatic test_full();
    build_frame(DEPTH, 1'b0);
    model_frame();
    send_frame();
    checks++;
    if (got_wa.size() != exp_wa.size()) begin
      errors++;
      $display("FAIL full_count: got %0d writes required %0d", got_wa.size(), exp_wa.size());
    end else begin
      foreach (exp_wa[i]) begin
        checks++;
        if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i]) begin
          errors++;
          $display("FAIL full_write[%0d]: got %0d/%h required %0d/%h",
                   i, got_wa[i], got_wd[i], exp_wa[i], exp_wd[i]);
        end
      end
      checks++;
      if (got_wa[DEPTH-1] !== AW'(63)) begin
        errors++;
        $display("FAIL full_last_addr: got %0d required 63", got_wa[DEPTH-1]);
      end
    end
    checks++;
    if ({done, error, cpu_reset, bad_op_count} !== {1'b1, 1'b0, 1'b0, exp_bad}) begin
      errors++;
      $display("FAIL full_status: got d=%b e=%b cr=%b bad=%0d required done, bad=%0d",
               done, error, cpu_reset, bad_op_count, exp_bad);
    end
  endtask

  task automatic test_bad_op();
    frame = '{8'h01, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h7F};
    send_frame();
    checks++;
    if ({got_wa.size() == 1, done, cpu_reset, bad_op_count} !== {1'b1, 1'b1, 1'b0, CW'(1)} ||
        got_wd[0] !== 32'h0000007F) begin
      errors++;
      $display("FAIL bad_op_load: got writes=%0d d=%b cr=%b bad=%0d required 1 write 0000007F, done, bad=1",
               got_wa.size(), done, cpu_reset, bad_op_count);
    end
    pulse_start();
    checks++;
    if ({bad_op_count, cpu_reset, done, rx_ready} !== {CW'(0), 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bad_op_restart: got bad=%0d cr=%b d=%b rdy=%b required bad=0 cr=1 d=0 rdy=1",
               bad_op_count, cpu_reset, done, rx_ready);
    end
    // Finish the pending load with an empty header to leave the loader in ERR.
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1; rx_data = 8'h00;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    checks++;
    if ({error, err_code} !== {1'b1, 2'b01}) begin
      errors++;
      $display("FAIL bad_op_tail: got e=%b ec=%b required e=1 ec=01", error, err_code);
    end
  endtask

  task automatic test_mid_reset();
    build_frame(2, 1'b0);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      rx_valid = 1'b1; rx_data = frame[i];
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({rx_ready, we, waddr, wdata, cpu_reset, done, error, err_code, bad_op_count} !==
        {1'b0, 1'b0, AW'(0), 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b we=%b wa=%0d wd=%h cr=%b d=%b e=%b ec=%b bad=%0d",
               rx_ready, we, waddr, wdata, cpu_reset, done, error, err_code, bad_op_count);
    end
  endtask

  task automatic test_random();
    int kind;
    gap_pct     = 30;
    noisy_start = 1'b1;
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(9);
      if (kind == 0) begin
        frame = '{8'h00, 8'h00};
      end else if (kind == 1) begin
        kind  = $urandom_range(300, DEPTH + 1);
        frame = '{8'(kind), 8'(kind >> 8)};
      end else begin
        build_frame($urandom_range(6, 1), $urandom_range(3) == 0);
      end
      model_frame();
      send_frame();
      checks++;
      if (got_wa.size() != exp_wa.size()) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d writes required %0d", it, got_wa.size(), exp_wa.size());
      end else begin
        foreach (exp_wa[i]) begin
          checks++;
          if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i]) begin
            errors++;
            $display("FAIL rand_write[%0d.%0d]: got %0d/%h required %0d/%h",
                     it, i, got_wa[i], got_wd[i], exp_wa[i], exp_wd[i]);
          end
        end
      end
      checks++;
      if ({done, error, err_code, cpu_reset, rx_ready, bad_op_count} !==
          {exp_done, exp_error, exp_code, ~exp_done, 1'b0, exp_bad}) begin
        errors++;
        $display("FAIL rand_status[%0d]: got d=%b e=%b ec=%b cr=%b bad=%0d required d=%b e=%b ec=%b bad=%0d",
                 it, done, error, err_code, cpu_reset, bad_op_count,
                 exp_done, exp_error, exp_code, exp_bad);
      end
    end
    gap_pct     = 0;
    noisy_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_length();
    test_full();
    test_bad_op();
    test_mid_reset();
    test_basic();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
